// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter_if : pipeline / vector / register-file write-port bundle  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface wb_port_arbiter_if;
  logic [1:0]  pipeWEn_i;
  logic [3:0]  pipeRd_i;
  logic [63:0] pipeData_i;
  logic        vecValid_i;
  logic        vecReady_o;
  logic [1:0]  vecWEn_i;
  logic [3:0]  vecRd_i;
  logic [63:0] vecData_i;
  logic [1:0]  rfWEn_o;
  logic [3:0]  rfRd_o;
  logic [63:0] rfData_o;
  logic        grantVec_o;
  logic        pipeStall_o;
  logic [2:0]  fifoCount_o;

  modport slave (
    input  pipeWEn_i, pipeRd_i, pipeData_i,
    input  vecValid_i, vecWEn_i, vecRd_i, vecData_i,
    output vecReady_o, rfWEn_o, rfRd_o, rfData_o,
    output grantVec_o, pipeStall_o, fifoCount_o
  );

  modport master (
    output pipeWEn_i, pipeRd_i, pipeData_i,
    output vecValid_i, vecWEn_i, vecRd_i, vecData_i,
    input  vecReady_o, rfWEn_o, rfRd_o, rfData_o,
    input  grantVec_o, pipeStall_o, fifoCount_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter : shares the RF write port between pipeline and vector    |
// | FIFO; WB_STARVE_GUARD_EN enables the forced-grant starvation guard.       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_port_arbiter_if.slave     bus
);

  localparam int         c_PTR_W     = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam logic [2:0] c_DEPTH_CNT = 3'(FIFO_DEPTH);

  logic [69:0]        r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [2:0]         r_count;
  logic [2:0]         w_count_nxt;
  logic               w_ready;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_pipe_req;
  logic               w_grant_pipe;
  logic               w_force;
  logic [69:0]        w_head;

  logic [1:0]         r_rf_wen;
  logic [3:0]         r_rf_rd;
  logic [63:0]        r_rf_data;
  logic               r_grant_vec;

  assign w_ready      = (r_count < c_DEPTH_CNT);
  assign w_empty      = (r_count == 3'd0);
  assign w_push       = bus.vecValid_i & w_ready;
  assign w_pipe_req   = (bus.pipeWEn_i != 2'b00);
  assign w_grant_pipe = w_pipe_req & ~w_force;
  // A FORCE cycle always pops: the FIFO cannot drain while the head is denied.
  assign w_pop        = ~w_empty & (w_force | ~w_pipe_req);
  assign w_head       = r_mem[r_head];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 3'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= {bus.vecWEn_i, bus.vecRd_i, bus.vecData_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_wen    <= 2'b00;
      r_rf_rd     <= 4'd0;
      r_rf_data   <= 64'd0;
      r_grant_vec <= 1'b0;
    end else if (w_grant_pipe) begin
      r_rf_wen    <= bus.pipeWEn_i;
      r_rf_rd     <= bus.pipeRd_i;
      r_rf_data   <= bus.pipeData_i;
      r_grant_vec <= 1'b0;
    end else if (w_pop) begin
      r_rf_wen    <= w_head[69:68];
      r_rf_rd     <= w_head[67:64];
      r_rf_data   <= w_head[63:0];
      r_grant_vec <= 1'b1;
    end else begin
      r_rf_wen    <= 2'b00;
      r_rf_rd     <= 4'd0;
      r_rf_data   <= 64'd0;
      r_grant_vec <= 1'b0;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;
  localparam logic [3:0] c_WAIT_LIM = 4'(MAX_WAIT - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_wait;
  logic [3:0] w_wait_nxt;
  logic       w_denied;

  assign w_denied = ~w_empty & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_denied) begin
          if (r_wait == c_WAIT_LIM) begin
            w_state_nxt = S_FORCE;
            w_wait_nxt  = 4'd0;
          end else begin
            w_state_nxt = S_WAIT;
            w_wait_nxt  = r_wait + 4'd1;
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_wait_nxt  = 4'd0;
        end
      end
      S_FORCE: begin
        w_wait_nxt  = 4'd0;
        w_state_nxt = (w_count_nxt != 3'd0) ? S_WAIT : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_force = (r_state == S_FORCE);
  end
`else
  assign w_force = 1'b0;
`endif

  assign bus.vecReady_o  = w_ready;
  assign bus.fifoCount_o = r_count;
  assign bus.pipeStall_o = w_force;
  assign bus.rfWEn_o     = r_rf_wen;
  assign bus.rfRd_o      = r_rf_rd;
  assign bus.rfData_o    = r_rf_data;
  assign bus.grantVec_o  = r_grant_vec;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_port_arbiter : directed scoreboard bench for wb_port_arbiter        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_wb_port_arbiter;

  typedef struct packed {
    logic [1:0]  wen;
    logic [3:0]  rd;
    logic [63:0] data;
    logic        gv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  wb_port_arbiter_if bus_if ();

  wb_port_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Every non-idle write on the RF port must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus_if.rfWEn_o != 2'b00 || bus_if.grantVec_o)) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got wen=%b rd=%h data=%h gv=%b, required no write",
                 bus_if.rfWEn_o, bus_if.rfRd_o, bus_if.rfData_o, bus_if.grantVec_o);
      end else begin
        e = sb_q.pop_front();
        if (bus_if.rfWEn_o !== e.wen || bus_if.rfRd_o !== e.rd ||
            bus_if.rfData_o !== e.data || bus_if.grantVec_o !== e.gv) begin
          n_fail++;
          $display("FAIL sb_write: got wen=%b rd=%h data=%h gv=%b, required wen=%b rd=%h data=%h gv=%b",
                   bus_if.rfWEn_o, bus_if.rfRd_o, bus_if.rfData_o, bus_if.grantVec_o,
                   e.wen, e.rd, e.data, e.gv);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic [1:0] wen, input logic [3:0] rd, input logic [63:0] data);
    bus_if.pipeWEn_i  = wen;
    bus_if.pipeRd_i   = rd;
    bus_if.pipeData_i = data;
  endtask

  task automatic set_vec(input logic v, input logic [1:0] wen, input logic [3:0] rd,
                         input logic [63:0] data);
    bus_if.vecValid_i = v;
    bus_if.vecWEn_i   = wen;
    bus_if.vecRd_i    = rd;
    bus_if.vecData_i  = data;
  endtask

  task automatic idle();
    set_pipe(2'b00, 4'h0, 64'h0);
    set_vec(1'b0, 2'b00, 4'h0, 64'h0);
  endtask

  task automatic expect_wr(input logic [1:0] wen, input logic [3:0] rd, input logic [63:0] data,
                           input logic gv);
    exp_t e;
    e.wen = wen; e.rd = rd; e.data = data; e.gv = gv;
    sb_q.push_back(e);
  endtask

  localparam logic [63:0] VDATA = 64'hDEAD_BEEF_0000_00E0;

  initial begin
    idle();
    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      set_pipe(2'($urandom), 4'($urandom), {$urandom, $urandom});
      set_vec(1'($urandom), 2'($urandom), 4'($urandom), {$urandom, $urandom});
      step();
    end
    chk("rst_rfWEn",     64'(bus_if.rfWEn_o),     64'd0);
    chk("rst_rfRd",      64'(bus_if.rfRd_o),      64'd0);
    chk("rst_rfData",    bus_if.rfData_o,         64'd0);
    chk("rst_grantVec",  64'(bus_if.grantVec_o),  64'd0);
    chk("rst_pipeStall", 64'(bus_if.pipeStall_o), 64'd0);
    chk("rst_fifoCount", 64'(bus_if.fifoCount_o), 64'd0);
    chk("rst_vecReady",  64'(bus_if.vecReady_o),  64'd1);
    idle();
    rst = 1'b1;
    step();

    // Release: single pipeline write
    set_pipe(2'b01, 4'h3, 64'hA5);
    expect_wr(2'b01, 4'h3, 64'hA5, 1'b0);
    step();
    idle();
    step();
    step();

    // Idle-slot drain of two vector results
    set_vec(1'b1, 2'b11, 4'h5, 64'h5555_0000_0000_0005);
    expect_wr(2'b11, 4'h5, 64'h5555_0000_0000_0005, 1'b1);
    step();
    chk("drain_ready", 64'(bus_if.vecReady_o), 64'd1);
    set_vec(1'b1, 2'b01, 4'h6, 64'h6666_0000_0000_0006);
    expect_wr(2'b01, 4'h6, 64'h6666_0000_0000_0006, 1'b1);
    step();
    idle();
    chk("drain_cnt1", 64'(bus_if.fifoCount_o), 64'd1);
    step();
    chk("drain_cnt0", 64'(bus_if.fifoCount_o), 64'd0);
    step();

    // Fill with pipeline busy, refuse when full, pop while full
    set_pipe(2'b01, 4'hA, 64'hAAAA);
    set_vec(1'b1, 2'b10, 4'h1, 64'h1111);
    expect_wr(2'b01, 4'hA, 64'hAAAA, 1'b0);
    step();
    chk("fill_cnt1", 64'(bus_if.fifoCount_o), 64'd1);
    set_pipe(2'b10, 4'hB, 64'hBBBB);
    set_vec(1'b1, 2'b01, 4'h2, 64'h2222);
    expect_wr(2'b10, 4'hB, 64'hBBBB, 1'b0);
    step();
    chk("full_cnt",   64'(bus_if.fifoCount_o), 64'd2);
    chk("full_ready", 64'(bus_if.vecReady_o),  64'd0);
    set_pipe(2'b11, 4'hC, 64'hCCCC);
    set_vec(1'b1, 2'b11, 4'h7, 64'h7777);
    expect_wr(2'b11, 4'hC, 64'hCCCC, 1'b0);
    step();
    chk("full_ready2", 64'(bus_if.vecReady_o), 64'd0);
    set_pipe(2'b00, 4'h0, 64'h0);
    set_vec(1'b1, 2'b11, 4'h8, 64'h8888);
    expect_wr(2'b10, 4'h1, 64'h1111, 1'b1);
    step();
    idle();
    chk("poppush_cnt",   64'(bus_if.fifoCount_o), 64'd1);
    chk("poppush_ready", 64'(bus_if.vecReady_o),  64'd1);
    expect_wr(2'b01, 4'h2, 64'h2222, 1'b1);
    step();
    chk("fill_empty", 64'(bus_if.fifoCount_o), 64'd0);
    step();
    step();

    // Starvation: continuous pipeline writes with one queued vector result
    set_pipe(2'b10, 4'h0, 64'h1000);
    set_vec(1'b1, 2'b01, 4'hE, VDATA);
    expect_wr(2'b10, 4'h0, 64'h1000, 1'b0);
    step();
    set_vec(1'b0, 2'b00, 4'h0, 64'h0);
`ifdef WB_STARVE_GUARD_EN
    for (int k = 1; k <= 8; k++) begin
      set_pipe(2'b10, 4'(k), 64'h1000 + 64'(k));
      expect_wr(2'b10, 4'(k), 64'h1000 + 64'(k), 1'b0);
      chk("starve_nostall", 64'(bus_if.pipeStall_o), 64'd0);
      step();
    end
    set_pipe(2'b10, 4'h9, 64'h1009);
    chk("starve_stall", 64'(bus_if.pipeStall_o), 64'd1);
    chk("starve_cnt",   64'(bus_if.fifoCount_o), 64'd1);
    expect_wr(2'b01, 4'hE, VDATA, 1'b1);
    step();
    chk("starve_stall_end", 64'(bus_if.pipeStall_o), 64'd0);
    expect_wr(2'b10, 4'h9, 64'h1009, 1'b0);
    step();
    idle();
`else
    for (int k = 1; k <= 9; k++) begin
      set_pipe(2'b10, 4'(k), 64'h1000 + 64'(k));
      expect_wr(2'b10, 4'(k), 64'h1000 + 64'(k), 1'b0);
      chk("nog_nostall", 64'(bus_if.pipeStall_o), 64'd0);
      step();
    end
    idle();
    chk("nog_queued", 64'(bus_if.fifoCount_o), 64'd1);
    expect_wr(2'b01, 4'hE, VDATA, 1'b1);
`endif
    step();
    chk("starve_empty", 64'(bus_if.fifoCount_o), 64'd0);
    step();
    step();

    // Asynchronous reset mid-operation discards the queued result
    set_pipe(2'b01, 4'hD, 64'hD00D);
    set_vec(1'b1, 2'b11, 4'hF, 64'hF00F);
    expect_wr(2'b01, 4'hD, 64'hD00D, 1'b0);
    step();
    idle();
    #5;
    chk("mid_cnt", 64'(bus_if.fifoCount_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_cnt",   64'(bus_if.fifoCount_o), 64'd0);
    chk("async_ready", 64'(bus_if.vecReady_o),  64'd1);
    chk("async_wen",   64'(bus_if.rfWEn_o),     64'd0);
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("post_rst_cnt", 64'(bus_if.fifoCount_o), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
